// File: rtl/knight_uart_pkg.sv
// Shared definitions for the robot-side UART command link: baud divider,
// response codes understood by cmd_proc and the remote sender, and the
// state encodings used by the receiver, transmitter and command assembler.
package knight_uart_pkg;

  // 50 MHz system clock divided down to 19200 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

  // Width of every baud-rate counter in the link
  localparam int BAUD_CNT_W = 12;

  // Response bytes sent back to the remote side
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] ACK     = 8'h5A;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic {
    WAIT_HIGH,
    WAIT_LOW
  } asm_state_t;

  // Serial frame as shifted out LSB first: start bit, data, stop bit
  function automatic logic [9:0] tx_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/knight_uart_rx.sv
// Serial byte receiver: synchronizes RX, detects the start edge, samples
// each bit in the middle of its period and emits a one-cycle rx_rdy pulse
// for every byte whose stop bit reads as 1.
module uart_rx
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  // First sample lands half a bit after the edge, the rest a full bit apart
  localparam logic [BAUD_CNT_W-1:0] HALF_LOAD = BAUD_CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] FULL_LOAD = BAUD_CNT_W'(BAUD_DIV - 1);

  rx_state_t             rx_state;
  rx_state_t             rx_nxt;
  logic                  rx_meta;
  logic                  rx_sync;
  logic                  rx_prev;
  logic                  start_edge;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [3:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic                  bit_tick;
  logic                  is_glitch;
  logic                  is_stop;

  // Two-flop synchronizer plus one history flop for edge detection, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign bit_tick   = (rx_state == RX_RECV) && (baud_cnt == '0);
  assign is_glitch  = bit_tick && (bit_cnt == 4'd0) && rx_sync;
  assign is_stop    = bit_tick && (bit_cnt == 4'd9);

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_nxt;
    end
  end

  // Next state: arm on a start edge, drop back on a glitch or after the stop sample
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE: begin
        if (start_edge) begin
          rx_nxt = RX_RECV;
        end
      end
      RX_RECV: begin
        if (is_glitch || is_stop) begin
          rx_nxt = RX_IDLE;
        end
      end
    endcase
  end

  // Baud and bit counters, data shift register and the byte-ready pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      rx_rdy    <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (start_edge) begin
          baud_cnt <= HALF_LOAD;
          bit_cnt  <= 4'd0;
        end
      end else if (bit_tick) begin
        if (is_glitch || is_stop) begin
          baud_cnt <= '0;
          bit_cnt  <= 4'd0;
          rx_rdy   <= is_stop & rx_sync;
        end else begin
          baud_cnt <= FULL_LOAD;
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt != 4'd0) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
          end
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  assign rx_data = shift_reg;

endmodule

// File: rtl/knight_uart_wrapper.sv
// Robot-side end of the command link: pairs received bytes into 16-bit
// commands for cmd_proc and serializes one-byte responses back over TX.
module knight_uart_wrapper
  import knight_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);

  logic [7:0]            rx_data;
  logic                  rx_rdy;

  asm_state_t            asm_state;
  asm_state_t            asm_nxt;
  logic                  latch_high;
  logic                  latch_cmd;
  logic [7:0]            high_byte;

  tx_state_t             tx_state;
  tx_state_t             tx_nxt;
  logic                  tx_load;
  logic                  tx_tick;
  logic                  tx_last;
  logic [9:0]            tx_shift;
  logic [BAUD_CNT_W-1:0] tx_baud;
  logic [3:0]            tx_bit;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy)
  );

  // Assembler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= WAIT_HIGH;
    end else begin
      asm_state <= asm_nxt;
    end
  end

  // Alternate between high and low byte on every received byte
  always_comb begin
    asm_nxt    = asm_state;
    latch_high = 1'b0;
    latch_cmd  = 1'b0;
    if (rx_rdy) begin
      case (asm_state)
        WAIT_HIGH: begin
          latch_high = 1'b1;
          asm_nxt    = WAIT_LOW;
        end
        WAIT_LOW: begin
          latch_cmd = 1'b1;
          asm_nxt   = WAIT_HIGH;
        end
      endcase
    end
  end

  // Command word and ready flag; a completing low byte beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= 8'h00;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
    end else begin
      if (latch_high) begin
        high_byte <= rx_data;
      end
      if (latch_cmd) begin
        cmd     <= {high_byte, rx_data};
        cmd_rdy <= 1'b1;
      end else if (latch_high || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  assign tx_tick = (tx_state == TX_SHIFT) && (tx_baud == BAUD_LAST);
  assign tx_last = tx_tick && (tx_bit == 4'd9);

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_nxt;
    end
  end

  // Accept trmt only while idle so a running frame is never disturbed
  always_comb begin
    tx_nxt  = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (trmt) begin
          tx_load = 1'b1;
          tx_nxt  = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_last) begin
          tx_nxt = TX_IDLE;
        end
      end
    endcase
  end

  // Shift register idles at all ones so TX rests high and resets high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= 4'd0;
      tx_done  <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= tx_frame(resp);
      tx_baud  <= '0;
      tx_bit   <= 4'd0;
      tx_done  <= 1'b0;
    end else if (tx_state == TX_SHIFT) begin
      if (tx_tick) begin
        tx_baud  <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        if (tx_last) begin
          tx_bit  <= 4'd0;
          tx_done <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  assign TX = tx_shift[0];

endmodule

// File: tb/tb_knight_uart_wrapper.sv
// Testbench for knight_uart_wrapper, run with a short baud divider so the
// whole sequence stays small; the command model pairs good bytes into words.
module tb_knight_uart_wrapper;
  import knight_uart_pkg::*;

  localparam int B = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX;
  logic        cmd_rdy;
  logic        tx_done;
  logic [15:0] cmd;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  logic [7:0]  exp_high = 8'h00;
  bit          have_high = 1'b0;

  logic [7:0]  mon_q[$];

  knight_uart_wrapper #(
    .BAUD_DIV (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (have_high) begin
      exp_cmd   = {exp_high, b};
      exp_rdy   = 1'b1;
      have_high = 1'b0;
    end else begin
      exp_high  = b;
      have_high = 1'b1;
      exp_rdy   = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    exp_cmd   = 16'h0000;
    exp_rdy   = 1'b0;
    have_high = 1'b0;
  endfunction

  task automatic check_cmd(input string tag);
    checkOutput({tag, "_cmd"}, cmd, exp_cmd);
    checkOutput({tag, "_rdy"}, cmd_rdy, exp_rdy);
  endtask

  // Drive one serial frame on RX; optionally hold clr_cmd_rdy through the
  // stop bit until cmd_rdy is seen high
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input bit hold_clr, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) RX = 1'b0;
      else if (k == 9) RX = stop_bit;
      else RX = data[k-1];
      for (int c = 0; c < B; c++) begin
        if (hold_clr && k == 9) begin
          if (cmd_rdy === 1'b1) seen = 1'b1;
          clr_cmd_rdy = !seen;
        end
        @(negedge clk);
      end
    end
    clr_cmd_rdy = 1'b0;
    RX = 1'b1;
    if (stop_bit) model_byte(data);
  endtask

  task automatic pulse_trmt(input logic [7:0] data);
    resp = data;
    trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
  endtask

  task automatic pulse_clr(input string tag);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    checkOutput({tag, "_clr_rdy"}, cmd_rdy, exp_rdy);
    checkOutput({tag, "_clr_cmd"}, cmd, exp_cmd);
  endtask

  task automatic wait_tx_done(input string tag);
    int n = 0;
    while (tx_done !== 1'b1 && n < 12 * B) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, tx_done, 32'd1);
  endtask

  // Independent serial receiver watching TX; decodes every frame it sees
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (B) @(negedge clk);
          b[k] = TX;
        end
        repeat (B) @(negedge clk);
        if (TX === 1'b1) mon_q.push_back(b);
      end
    end
  end

  initial begin : stimulus
    bit         seen;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] rb;
    logic [9:0] ack_bits;
    logic       exp_bit;

    $display("[TB] starting knight_uart_wrapper bench, BAUD_DIV=%0d", B);

    // Reset values
    tick(3);
    checkOutput("reset_TX", TX, 32'd1);
    checkOutput("reset_tx_done", tx_done, 32'd0);
    check_cmd("reset");
    rst_n = 1'b1;
    tick(2 * B);
    check_cmd("after_reset");

    // Command assembly and clear
    applyStimulus(8'h29, 1'b1, 1'b0, seen);
    applyStimulus(8'h35, 1'b1, 1'b0, seen);
    check_cmd("assemble");
    checkOutput("assemble_literal", cmd, 32'h2935);
    pulse_clr("assemble");

    // Positive ack: exact bit values and bit lengths
    mon_q.delete();
    ack_bits = 10'b11_0100_1010;
    pulse_trmt(POS_ACK);
    for (int i = 0; i < 10; i++) begin
      exp_bit = ack_bits[i];
      checkOutput($sformatf("ack_bit%0d_first", i), TX, exp_bit);
      tick(B - 1);
      checkOutput($sformatf("ack_bit%0d_last", i), TX, exp_bit);
      if (i == 9) checkOutput("ack_done_early", tx_done, 32'd0);
      tick(1);
    end
    checkOutput("ack_tx_done", tx_done, 32'd1);
    tick(B);
    checkOutput("ack_done_hold", tx_done, 32'd1);
    checkOutput("ack_TX_idle", TX, 32'd1);
    checkOutput("ack_frames", mon_q.size(), 32'd1);
    if (mon_q.size() > 0) checkOutput("ack_byte", mon_q.pop_front(), POS_ACK);

    // Ack with a trmt arriving mid-frame
    mon_q.delete();
    pulse_trmt(ACK);
    tick(5 * B);
    pulse_trmt(8'hFF);
    wait_tx_done("busy_done");
    tick(12 * B);
    checkOutput("busy_frames", mon_q.size(), 32'd1);
    if (mon_q.size() > 0) checkOutput("busy_byte", mon_q.pop_front(), ACK);
    checkOutput("busy_done_hold", tx_done, 32'd1);

    // Reset in the middle of a low byte and of a TX frame
    applyStimulus(8'h77, 1'b1, 1'b0, seen);
    check_cmd("rst_high");
    pulse_trmt(8'h00);
    RX = 1'b0;
    tick(2 * B);
    checkOutput("rst_TX_busy", TX, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_async_TX", TX, 32'd1);
    checkOutput("rst_tx_done", tx_done, 32'd0);
    check_cmd("rst_async");
    RX = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(B);
    check_cmd("rst_released");
    applyStimulus(8'hAB, 1'b1, 1'b0, seen);
    applyStimulus(8'hCD, 1'b1, 1'b0, seen);
    check_cmd("post_reset");
    checkOutput("post_reset_literal", cmd, 32'hABCD);
    tick(12 * B);
    mon_q.delete();

    // Framing error and a short glitch are both ignored
    pulse_clr("pre_frame");
    applyStimulus(8'h12, 1'b0, 1'b0, seen);
    tick(B);
    RX = 1'b0;
    tick(B / 4);
    RX = 1'b1;
    tick(B);
    check_cmd("frame_glitch_idle");
    applyStimulus(8'h34, 1'b1, 1'b0, seen);
    applyStimulus(8'h56, 1'b1, 1'b0, seen);
    check_cmd("framing");
    checkOutput("framing_literal", cmd, 32'h3456);

    // clr_cmd_rdy coinciding with the completing low byte
    applyStimulus(8'hC3, 1'b1, 1'b0, seen);
    applyStimulus(8'h3C, 1'b1, 1'b1, seen);
    checkOutput("overlap_seen", seen, 32'd1);
    check_cmd("overlap");

    // Randomized full-duplex traffic
    for (int r = 0; r < 6; r++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      rb = 8'($urandom);
      mon_q.delete();
      pulse_trmt(rb);
      applyStimulus(hi, 1'b1, 1'b0, seen);
      check_cmd($sformatf("rand%0d_hi", r));
      applyStimulus(lo, 1'b1, 1'b0, seen);
      check_cmd($sformatf("rand%0d_lo", r));
      checkOutput($sformatf("rand%0d_tx_done", r), tx_done, 32'd1);
      checkOutput($sformatf("rand%0d_frames", r), mon_q.size(), 32'd1);
      if (mon_q.size() > 0) checkOutput($sformatf("rand%0d_byte", r), mon_q.pop_front(), rb);
      if (r % 2 == 0) pulse_clr($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
